// File: rtl/xcorr_engine_pkg.sv
// Shared constants, types and helpers for the TDOA cross-correlation engine.
package xcorr_pkg;

  localparam int NUM_BITS_SAMPLE = 12;
  localparam int NUM_SAMPLES     = 1024;
  localparam int MAX_LAGS        = 17;
  localparam int NUM_LAGS        = 2 * MAX_LAGS + 1;
  localparam int NUM_BITS_XCORRS = 2 * NUM_BITS_SAMPLE + $clog2(NUM_SAMPLES);
  localparam int LAG_IDX_W       = $clog2(NUM_LAGS);
  localparam int CNT_W           = $clog2(NUM_SAMPLES);

  typedef logic signed [NUM_BITS_SAMPLE-1:0] sample_t;
  typedef logic signed [NUM_BITS_XCORRS-1:0] xcorr_t;
  typedef logic [LAG_IDX_W-1:0]              lag_idx_t;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, SCAN} state_t;

  // Full-precision signed product, sign-extended to accumulator width.
  function automatic xcorr_t widen_product(input sample_t a, input sample_t b);
    logic signed [2*NUM_BITS_SAMPLE-1:0] p;
    p = a * b;
    return xcorr_t'(p);
  endfunction

endpackage

// File: rtl/xcorr_engine_if.sv
// Sample-in / result-out bundle between the sample source, the engine and the peak finder.
interface xcorr_engine_if;
  import xcorr_pkg::*;

  logic                       start;
  logic                       sampleValid;
  sample_t                    sampleA;
  sample_t                    sampleB;
  xcorr_t [NUM_LAGS-1:0]      xcorrs;
  lag_idx_t                   iterator;
  logic                       scanValid;
  logic                       busy;
  logic                       done;

  modport master (
    output start, sampleValid, sampleA, sampleB,
    input  xcorrs, iterator, scanValid, busy, done
  );

  modport slave (
    input  start, sampleValid, sampleA, sampleB,
    output xcorrs, iterator, scanValid, busy, done
  );

endinterface

// File: rtl/xcorr_engine_mac_lane.sv
// One correlation tap: accumulates aDel * b[k] on every shift of the delay lines.
module xcorr_mac_lane
  import xcorr_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_clear,
  input  logic    i_shift,
  input  sample_t i_a_del,
  input  sample_t i_b_tap,
  output xcorr_t  o_acc
);

  xcorr_t r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_shift) begin
      r_acc <= r_acc + widen_product(i_a_del, i_b_tap);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/xcorr_engine.sv
// Frame-based cross-correlator of two sample streams over lags -MAX_LAGS..+MAX_LAGS,
// followed by a one-index-per-cycle scan for the downstream peak finder.
module xcorr_engine
  import xcorr_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  xcorr_engine_if.slave  bus
);

  localparam logic [CNT_W-1:0]     LAST_SAMPLE = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0]     LAST_FLUSH  = CNT_W'(MAX_LAGS - 1);
  localparam lag_idx_t             LAST_LAG    = LAG_IDX_W'(NUM_LAGS - 1);

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  lag_idx_t           r_iter, w_iter_next;
  logic               r_done, w_done_next;
  logic               w_clear, w_shift, w_flush;

  sample_t            w_a_in, w_b_in;
  sample_t            r_a_dly [MAX_LAGS];
  sample_t            w_a_src [MAX_LAGS+1];
  sample_t            r_b_dly [NUM_LAGS-1];
  sample_t            w_b_tap [NUM_LAGS];
  xcorr_t             w_acc   [NUM_LAGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_iter  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_iter  <= w_iter_next;
      r_done  <= w_done_next;
    end
  end

  // start wins over everything, including a coincident sampleValid.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_iter_next  = r_iter;
    w_done_next  = 1'b0;
    w_clear      = 1'b0;
    w_shift      = 1'b0;
    w_flush      = 1'b0;
    if (bus.start) begin
      w_clear      = 1'b1;
      w_cnt_next   = '0;
      w_state_next = ACCUM;
    end else begin
      case (r_state)
        ACCUM: begin
          if (bus.sampleValid) begin
            w_shift = 1'b1;
            if (r_cnt == LAST_SAMPLE) begin
              w_cnt_next   = '0;
              w_state_next = FLUSH;
            end else begin
              w_cnt_next = r_cnt + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          w_shift = 1'b1;
          w_flush = 1'b1;
          if (r_cnt == LAST_FLUSH) begin
            w_cnt_next   = '0;
            w_iter_next  = '0;
            w_state_next = SCAN;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        SCAN: begin
          if (r_iter == LAST_LAG) begin
            w_done_next  = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_iter_next = r_iter + LAG_IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_a_in     = w_flush ? '0 : bus.sampleA;
  assign w_b_in     = w_flush ? '0 : bus.sampleB;
  assign w_a_src[0] = w_a_in;
  assign w_b_tap[0] = w_b_in;

  // A is delayed MAX_LAGS so the centre tap of the B line lines up with lag 0.
  for (genvar gi = 0; gi < MAX_LAGS; gi++) begin : g_a_dly
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_a_dly[gi] <= '0;
      end else if (w_clear) begin
        r_a_dly[gi] <= '0;
      end else if (w_shift) begin
        r_a_dly[gi] <= w_a_src[gi];
      end
    end
    assign w_a_src[gi+1] = r_a_dly[gi];
  end

  for (genvar gi = 0; gi < NUM_LAGS - 1; gi++) begin : g_b_dly
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_b_dly[gi] <= '0;
      end else if (w_clear) begin
        r_b_dly[gi] <= '0;
      end else if (w_shift) begin
        r_b_dly[gi] <= w_b_tap[gi];
      end
    end
    assign w_b_tap[gi+1] = r_b_dly[gi];
  end

  for (genvar gi = 0; gi < NUM_LAGS; gi++) begin : g_lane
    xcorr_mac_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_clear),
      .i_shift (w_shift),
      .i_a_del (w_a_src[MAX_LAGS]),
      .i_b_tap (w_b_tap[gi]),
      .o_acc   (w_acc[gi])
    );
    assign bus.xcorrs[gi] = w_acc[gi];
  end

  assign bus.iterator  = r_iter;
  assign bus.scanValid = (r_state == SCAN);
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;

endmodule

// File: tb/tb_xcorr_engine.sv
// Frame-level bench for xcorr_engine: reference sums computed directly from the
// stimulus, queued per lag, and popped as the engine scans its results out.
module tb_xcorr_engine;
  import xcorr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  xcorr_engine_if bus ();

  xcorr_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     mode;
    int     stall;
    bit     anchors;
    longint e17;
    longint e16;
    longint e14;
    longint e0;
    longint e34;
  } vec_t;

  typedef struct {
    int     idx;
    longint val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   sa [NUM_SAMPLES];
  int   sb [NUM_SAMPLES];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint get_x(input int k);
    xcorr_t t;
    t = bus.xcorrs[k];
    return longint'(t);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pattern(input int mode);
    for (int n = 0; n < NUM_SAMPLES; n++) begin
      case (mode)
        0: begin sa[n] = 1; sb[n] = 1; end
        1: begin sa[n] = (n == 5) ? 100 : 0; sb[n] = (n == 8) ? 50 : 0; end
        2: begin sa[n] = -2048; sb[n] = -2048; end
        default: begin
          sa[n] = int'($urandom_range(4095)) - 2048;
          sb[n] = int'($urandom_range(4095)) - 2048;
        end
      endcase
    end
  endtask

  // xcorr[l] = sum a[m]*b[m-l], over samples inside the frame only.
  task automatic push_model();
    exp_t   e;
    longint s;
    int     l;
    int     j;
    for (int k = 0; k < NUM_LAGS; k++) begin
      l = k - MAX_LAGS;
      s = 0;
      for (int m = 0; m < NUM_SAMPLES; m++) begin
        j = m - l;
        if (j >= 0 && j < NUM_SAMPLES) s += longint'(sa[m]) * longint'(sb[j]);
      end
      e.idx = k;
      e.val = s;
      sb_q.push_back(e);
    end
  endtask

  // Start is issued with a junk valid sample that must not be accumulated.
  task automatic drive_frame(input int stall, input int nsamp);
    bus.sampleValid = 1'b1;
    bus.sampleA     = sample_t'(777);
    bus.sampleB     = sample_t'(-555);
    bus.start       = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("busy_after_start", longint'(bus.busy), 1);
    for (int n = 0; n < nsamp; n++) begin
      bus.sampleValid = 1'b0;
      bus.sampleA     = sample_t'(321);
      bus.sampleB     = sample_t'(-123);
      repeat (stall - 1) cyc();
      bus.sampleValid = 1'b1;
      bus.sampleA     = sample_t'(sa[n]);
      bus.sampleB     = sample_t'(sb[n]);
      cyc();
    end
    bus.sampleValid = 1'b0;
    bus.sampleA     = '0;
    bus.sampleB     = '0;
  endtask

  task automatic finish_frame(input string tag);
    int lat;
    int d;
    lat = 1;
    while (!bus.scanValid && lat < 100) begin
      cyc();
      lat++;
    end
    check({tag, "_scan_latency"}, lat, MAX_LAGS + 1);
    d = 0;
    while (!bus.done && d < 200) begin
      cyc();
      d++;
    end
    check({tag, "_done_latency"}, d, NUM_LAGS);
    cyc();
    check({tag, "_done_width"}, longint'(bus.done), 0);
    check({tag, "_idle_busy"}, longint'(bus.busy), 0);
    check({tag, "_iter_hold"}, longint'(bus.iterator), NUM_LAGS - 1);
    check({tag, "_sb_drain"}, sb_q.size(), 0);
  endtask

  task automatic check_anchors(input string tag, input vec_t v);
    check({tag, "_x17"}, get_x(17), v.e17);
    check({tag, "_x16"}, get_x(16), v.e16);
    check({tag, "_x14"}, get_x(14), v.e14);
    check({tag, "_x0"},  get_x(0),  v.e0);
    check({tag, "_x34"}, get_x(34), v.e34);
  endtask

  // Scoreboard: one expected lag result per scanned index.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.scanValid) begin
        if (sb_q.size() == 0) begin
          check("scan_unexpected", longint'(bus.iterator), -1);
        end else begin
          e = sb_q.pop_front();
          check("scan_iter", longint'(bus.iterator), e.idx);
          check("scan_xcorr", get_x(e.idx), e.val);
          $display("scan idx=%0d xcorr=%0d exp=%0d", e.idx, get_x(e.idx), e.val);
        end
      end
      if (!rst && bus.done) done_cnt++;
    end
  end

  initial begin
    vec_t vecs [5];
    vec_t dc;
    int   d0;
    int   w;
    int   nz;

    vecs[0] = '{0, 1, 1'b1, 1024, 1023, 1021, 1007, 1007};
    vecs[1] = '{1, 1, 1'b1, 0, 0, 5000, 0, 0};
    vecs[2] = '{2, 1, 1'b1, 64'd4294967296, 64'd4290772992, 64'd4282384384,
                64'd4223664128, 64'd4223664128};
    vecs[3] = '{0, 3, 1'b1, 1024, 1023, 1021, 1007, 1007};
    vecs[4] = '{3, 1, 1'b0, 0, 0, 0, 0, 0};
    dc = vecs[0];

    bus.start       = 1'b0;
    bus.sampleValid = 1'b0;
    bus.sampleA     = '0;
    bus.sampleB     = '0;

    repeat (2) @(posedge clk);
    #1;
    nz = 0;
    for (int k = 0; k < NUM_LAGS; k++) if (get_x(k) != 0) nz++;
    check("reset_xcorrs_nonzero", nz, 0);
    check("reset_iterator", longint'(bus.iterator), 0);
    check("reset_scanValid", longint'(bus.scanValid), 0);
    check("reset_busy", longint'(bus.busy), 0);
    check("reset_done", longint'(bus.done), 0);
    rst = 1'b0;
    cyc();

    bus.sampleValid = 1'b1;
    bus.sampleA     = sample_t'(300);
    bus.sampleB     = sample_t'(300);
    repeat (3) cyc();
    check("idle_ignores_valid", longint'(bus.busy), 0);

    for (int i = 0; i < 5; i++) begin
      load_pattern(vecs[i].mode);
      push_model();
      drive_frame(vecs[i].stall, NUM_SAMPLES);
      finish_frame($sformatf("vec%0d", i));
      if (vecs[i].anchors) check_anchors($sformatf("vec%0d", i), vecs[i]);
      $display("frame vec%0d mode=%0d stall=%0d x17=%0d", i, vecs[i].mode, vecs[i].stall, get_x(17));
    end

    // Abort mid-accumulation, then a clean DC frame.
    load_pattern(0);
    d0 = done_cnt;
    drive_frame(1, 500);
    push_model();
    drive_frame(1, NUM_SAMPLES);
    finish_frame("abort");
    check_anchors("abort", dc);
    check("abort_done_count", done_cnt - d0, 1);
    $display("frame abort x17=%0d done_pulses=%0d", get_x(17), done_cnt - d0);

    // Asynchronous reset while scanning index 10.
    push_model();
    drive_frame(1, NUM_SAMPLES);
    w = 0;
    while (!(bus.scanValid && bus.iterator == LAG_IDX_W'(10)) && w < 200) begin
      cyc();
      w++;
    end
    check("rst_reach_iter10", longint'(w < 200), 1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_scanValid", longint'(bus.scanValid), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_iterator", longint'(bus.iterator), 0);
    check("rst_done", longint'(bus.done), 0);
    nz = 0;
    for (int k = 0; k < NUM_LAGS; k++) if (get_x(k) != 0) nz++;
    check("rst_xcorrs_nonzero", nz, 0);
    sb_q.delete();
    d0 = done_cnt;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (2) cyc();
    check("rst_no_done", done_cnt - d0, 0);
    $display("frame rst_in_scan cleared, done_pulses=%0d", done_cnt - d0);

    push_model();
    drive_frame(1, NUM_SAMPLES);
    finish_frame("post_rst");
    check_anchors("post_rst", dc);
    $display("frame post_rst x17=%0d", get_x(17));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xcorr_engine.md
Name: xcorr_engine

Overview:
- Sits directly upstream of the peak finder in the TDOA chain.
- Accumulates the cross-correlation of two microphone sample streams A and B over one frame of NUM_SAMPLES sample pairs, for lags -MAX_LAGS..+MAX_LAGS.
- Then presents the 2*MAX_LAGS+1 results as a held parallel bus, with a lag-index sweep and a frame-done pulse, so the peak finder can scan one index per cycle.

Parameters:
- NUM_BITS_SAMPLE, 12: signed sample width.
- NUM_SAMPLES, 1024: sample pairs per frame.
- MAX_LAGS, 17: maximum lag magnitude; NUM_LAGS = 2*MAX_LAGS+1.
- NUM_BITS_XCORRS, 34: accumulator width, = 2*NUM_BITS_SAMPLE + $clog2(NUM_SAMPLES).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a new frame.
- sampleValid  in  1  sampleA/sampleB are valid this cycle.
- sampleA  in  NUM_BITS_SAMPLE  signed sample, channel A.
- sampleB  in  NUM_BITS_SAMPLE  signed sample, channel B.
- xcorrs  out  NUM_LAGS x NUM_BITS_XCORRS  signed results; index k = lag k-MAX_LAGS.
- iterator  out  $clog2(NUM_LAGS)  lag index swept during SCAN.
- scanValid  out  1  iterator is valid this cycle.
- busy  out  1  high in ACCUM, FLUSH and SCAN.
- done  out  1  one-cycle pulse after the last SCAN index.

Behaviour:
- Reset values: all accumulators, delay lines and counters 0; state IDLE; xcorrs=0, iterator=0, scanValid=0, busy=0, done=0.
- Datapath:
  - A delay line, MAX_LAGS deep.
  - B delay line with NUM_LAGS taps b[0..2L], where b[k] = B delayed k shifts.
  - On each shift, acc[k] += aDel * b[k], where aDel = A delayed MAX_LAGS.
  - Resulting definition: xcorr[l] = sum a[m]*b[m-l]. Positive lag means B leads A.
  - Products are 2*NUM_BITS_SAMPLE signed, sign-extended to NUM_BITS_XCORRS. No saturation is needed; the width is sized for the worst case.
- A shift occurs only on an accepted sample (ACCUM with sampleValid) or on every FLUSH cycle (zeros shifted in). Accumulators update on the same edge as the shift.
- FSM:
  - IDLE:
    - start -> clear accumulators, delay lines and sampleCnt; go to ACCUM.
    - sampleValid in IDLE is ignored.
  - ACCUM:
    - Each sampleValid: shift, accumulate, sampleCnt++.
    - The NUM_SAMPLES-th accepted sample -> FLUSH.
    - Invalid cycles stall with no shift.
  - FLUSH:
    - Exactly MAX_LAGS cycles of zero-input shifts, making each lag sum symmetric over the whole frame.
    - Then -> SCAN.
    - sampleValid is ignored.
  - SCAN:
    - scanValid=1; iterator = 0, 1, ..., NUM_LAGS-1, one per cycle.
    - After the cycle with iterator=NUM_LAGS-1 -> IDLE, with done=1 for one cycle.
    - iterator holds at NUM_LAGS-1 after SCAN.
- xcorrs is driven straight from the accumulators. It is stable from FLUSH end until the next start clears it.
- start in ACCUM, FLUSH or SCAN aborts the frame: same clearing as from IDLE, re-enter ACCUM next cycle, no done pulse.
- start coincident with sampleValid: the sample is not accumulated. The first sample is taken in the cycle after start.
- rst mid-frame: immediate return to reset values.
- Latency from the last accepted sample to the first scanValid: MAX_LAGS+1 cycles. Latency from there to done: NUM_LAGS cycles.

Decomposition:
- Package xcorr_pkg:
  - constants NUM_LAGS and LAG_IDX_W=$clog2(NUM_LAGS);
  - typedef xcorr_t (signed NUM_BITS_XCORRS);
  - state enum {IDLE, ACCUM, FLUSH, SCAN}.
- Sub-module xcorr_mac_lane: one tap.
  - Inputs: clear, shift enable, aDel, b tap.
  - Output: accumulator.
  - Instantiated NUM_LAGS times in a generate loop.

Test Plan:
- DC frame: A=B=1 for 1024 valid samples -> xcorrs[17]=1024, xcorrs[0]=xcorrs[34]=1007, xcorrs[k]=1024-|k-17|. Then scanValid for 35 cycles with iterator 0..34, then done pulse.
- Impulse: A=100 at n=5, B=50 at n=8, all else 0 -> xcorrs[14]=5000, all other indices 0.
- Full-scale: A=B=-2048 for the whole frame -> xcorrs[17]=2^32 with no overflow; xcorrs[16]=1023*4194304.
- Stalled input: valid asserted every third cycle -> results identical to the DC case; ACCUM lasts 3*1024 cycles.
- Abort: start pulse after 500 samples, then a full DC frame -> results equal a clean DC frame; only one done pulse.
- Async rst asserted during SCAN (iterator=10) -> all outputs 0 immediately; no done pulse; a following start runs a normal frame.
